// File: rtl/ip_codma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ip_codma_pkg
// Brief  : Shared codma types, transfer size codes and size-to-beat decoding.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package ip_codma_pkg;

  typedef enum logic [2:0] {
    RSP_IDLE    = 3'd0,
    RSP_GRANT   = 3'd1,
    RSP_RD_WAIT = 3'd2,
    RSP_RD_BEAT = 3'd3,
    RSP_WR_BEAT = 3'd4,
    RSP_ERROR   = 3'd5
  } rsp_state_t;

  localparam logic [3:0] CODMA_SIZE_2W = 4'd3;
  localparam logic [3:0] CODMA_SIZE_6W = 4'd8;
  localparam logic [3:0] CODMA_SIZE_8W = 4'd9;

  // Each beat carries two 32-bit words; zero marks an illegal size code.
  function automatic logic [2:0] codma_size_to_beats(input logic [3:0] size);
    case (size)
      CODMA_SIZE_2W: return 3'd1;
      CODMA_SIZE_6W: return 3'd3;
      CODMA_SIZE_8W: return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_codma_mem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ip_codma_mem_responder_if
// Brief  : codma memory bus between an initiator (master) and a responder (slave).
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface ip_codma_mem_responder_if;
  logic        req_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [3:0]  size_i;
  logic        write_valid_i;
  logic [63:0] write_data_i;
  logic        abort_i;
  logic        grant_o;
  logic        read_valid_o;
  logic [63:0] read_data_o;
  logic        error_o;
  logic        busy_o;

  modport slave (
    input  req_i, write_i, addr_i, size_i, write_valid_i, write_data_i, abort_i,
    output grant_o, read_valid_o, read_data_o, error_o, busy_o
  );

  modport master (
    output req_i, write_i, addr_i, size_i, write_valid_i, write_data_i, abort_i,
    input  grant_o, read_valid_o, read_data_o, error_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ip_codma_rsp_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ip_codma_rsp_ram
// Brief  : MEM_WORDS x 32 RAM organised as 64-bit word pairs, registered read.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module ip_codma_rsp_ram #(
  parameter int MEM_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic [$clog2(MEM_WORDS)-2:0]   rd_addr_i,
  output logic [63:0]                    rd_data_o,
  input  logic                           wr_en_i,
  input  logic [$clog2(MEM_WORDS)-2:0]   wr_addr_i,
  input  logic [63:0]                    wr_data_i
);

  logic [63:0] mem_q [MEM_WORDS/2];
  logic [63:0] rd_data_q;

  // Lower address word sits in [31:0], matching the bus beat packing.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ip_codma_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ip_codma_mem_responder
// Brief  : codma memory-side responder backed by an internal RAM.
//          Define CODMA_RSP_STALL_EN to insert an idle cycle between read beats.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module ip_codma_mem_responder
  import ip_codma_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  ip_codma_mem_responder_if.slave   bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = AW - 1;

  rsp_state_t    state_q, state_d;
  logic [PW-1:0] base_q, base_d;
  logic [2:0]    beats_q, beats_d;
  logic [2:0]    beat_cnt_q, beat_cnt_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          write_q, write_d;
`ifdef CODMA_RSP_STALL_EN
  logic          gap_q, gap_d;
`endif

  logic [2:0]    req_beats;
  logic          req_bad;
  logic          last_beat;
  logic [2:0]    rd_beat;
  logic          ram_we;
  logic          rd_valid;
  logic [PW-1:0] rd_addr;
  logic [PW-1:0] wr_addr;
  logic [63:0]   ram_rd_data;

  assign req_beats = codma_size_to_beats(bus.size_i);
  assign req_bad   = (req_beats == 3'd0) || (bus.addr_i[2:0] != 3'd0) ||
                     (({1'b0, bus.addr_i} + {27'd0, req_beats, 3'd0}) > 33'(4 * MEM_WORDS));
  assign last_beat = (beat_cnt_q == beats_q - 3'd1);
  assign rd_addr   = base_q + PW'(rd_beat);
  assign wr_addr   = base_q + PW'(beat_cnt_q);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
`ifdef CODMA_RSP_STALL_EN
    gap_d      = gap_q;
`endif
    rd_beat    = 3'd0;
    ram_we     = 1'b0;

    case (state_q)
      RSP_IDLE: begin
        beat_cnt_d = 3'd0;
        wait_cnt_d = 4'd0;
`ifdef CODMA_RSP_STALL_EN
        gap_d      = 1'b0;
`endif
        if (bus.req_i) begin
          base_d  = PW'(bus.addr_i[31:3]);
          beats_d = req_beats;
          write_d = bus.write_i;
          state_d = req_bad ? RSP_ERROR : RSP_GRANT;
        end
      end
      RSP_GRANT: begin
        if (write_q)              state_d = RSP_WR_BEAT;
        else if (RD_LATENCY == 1) state_d = RSP_RD_BEAT;
        else                      state_d = RSP_RD_WAIT;
      end
      RSP_RD_WAIT: begin
        if ((int'(wait_cnt_q) + 2) >= RD_LATENCY) state_d    = RSP_RD_BEAT;
        else                                      wait_cnt_d = wait_cnt_q + 4'd1;
      end
      RSP_RD_BEAT: begin
        // RAM read is one cycle ahead of the beat being presented.
        rd_beat = beat_cnt_q + 3'd1;
`ifdef CODMA_RSP_STALL_EN
        if (gap_q) begin
          gap_d      = 1'b0;
          beat_cnt_d = beat_cnt_q + 3'd1;
        end else if (last_beat) begin
          state_d = RSP_IDLE;
        end else begin
          gap_d = 1'b1;
        end
`else
        if (last_beat) state_d    = RSP_IDLE;
        else           beat_cnt_d = beat_cnt_q + 3'd1;
`endif
      end
      RSP_WR_BEAT: begin
        if (bus.write_valid_i) begin
          ram_we = 1'b1;
          if (last_beat) state_d    = RSP_IDLE;
          else           beat_cnt_d = beat_cnt_q + 3'd1;
        end
      end
      RSP_ERROR: state_d = RSP_IDLE;
      default:   state_d = RSP_IDLE;
    endcase

    if (bus.abort_i && (state_q != RSP_IDLE)) begin
      state_d = RSP_IDLE;
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= RSP_IDLE;
      base_q     <= '0;
      beats_q    <= 3'd0;
      beat_cnt_q <= 3'd0;
      wait_cnt_q <= 4'd0;
      write_q    <= 1'b0;
`ifdef CODMA_RSP_STALL_EN
      gap_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
`ifdef CODMA_RSP_STALL_EN
      gap_q      <= gap_d;
`endif
    end
  end

  ip_codma_rsp_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
    .clk_i     (clk_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_data),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (bus.write_data_i)
  );

`ifdef CODMA_RSP_STALL_EN
  assign rd_valid = (state_q == RSP_RD_BEAT) && !gap_q && !bus.abort_i;
`else
  assign rd_valid = (state_q == RSP_RD_BEAT) && !bus.abort_i;
`endif

  assign bus.grant_o      = (state_q == RSP_GRANT);
  assign bus.read_valid_o = rd_valid;
  assign bus.read_data_o  = rd_valid ? ram_rd_data : 64'd0;
  assign bus.error_o      = (state_q == RSP_ERROR);
  assign bus.busy_o       = (state_q != RSP_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ip_codma_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_ip_codma_mem_responder
// Brief  : Randomised self-checking bench for the codma memory responder.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_ip_codma_mem_responder;

  localparam int MW  = 256;
  localparam int RDL = 2;
`ifdef CODMA_RSP_STALL_EN
  localparam int STALL = 1;
`else
  localparam int STALL = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ip_codma_mem_responder_if bus();

  ip_codma_mem_responder #(.MEM_WORDS(MW), .RD_LATENCY(RDL)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [MW];
  logic [63:0] wbeats [4];

  // Bus monitor: everything observed at the falling edge.
  int cyc = 0, g_cnt = 0, g_cyc = 0, e_cnt = 0, b_cnt = 0;
  logic [63:0] rq [$];
  int          rc [$];
  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (bus.grant_o) begin g_cnt++; g_cyc = cyc; end
      if (bus.error_o) e_cnt++;
      if (bus.busy_o)  b_cnt++;
      if (bus.read_valid_o) begin rq.push_back(bus.read_data_o); rc.push_back(cyc); end
    end
  end

  int sg, se, sb, sq, gaps;
  bit to_flag, abort_busy;

  function automatic int exp_beats(input logic [3:0] s);
    case (s)
      4'd3:    return 1;
      4'd8:    return 3;
      4'd9:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input logic [3:0] s);
    int nb = exp_beats(s);
    return (nb == 0) || (a % 8 != 0) || (longint'(a) + 8 * nb > 4 * MW);
  endfunction

  function automatic logic [63:0] exp_beat(input logic [31:0] a, input int k);
    int w = (int'(a >> 2) + 2 * k) % MW;
    return {mdl[(w + 1) % MW], mdl[w]};
  endfunction

  function automatic void model_write(input logic [31:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      int w = (int'(a >> 2) + 2 * k) % MW;
      mdl[w]     = wbeats[k][31:0];
      mdl[w + 1] = wbeats[k][63:32];
    end
  endfunction

  // Initiator driver: request, wait for grant/error, stream write beats, wait for idle.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [3:0] s,
                     input int abort_beat, input bit rnd);
    int  t;
    bit  got_g, got_e;
    @(posedge clk); #1;
    sg = g_cnt; se = e_cnt; sb = b_cnt; sq = rq.size(); gaps = 0; to_flag = 0;
    bus.req_i = 1'b1; bus.write_i = wr; bus.addr_i = a; bus.size_i = s;
    if (!wr && rnd) begin
      bus.write_valid_i = 1'b1;
      bus.write_data_i  = {$urandom, $urandom};
    end
    got_g = 0; got_e = 0; t = 0;
    while (!got_g && !got_e && t < 10) begin
      @(negedge clk);
      got_g = bus.grant_o; got_e = bus.error_o; t++;
    end
    if (!got_g && !got_e) to_flag = 1;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    if (wr && got_g) begin
      for (int k = 0; k < exp_beats(s); k++) begin
        if (rnd && $urandom_range(0, 3) == 0) begin
          bus.write_valid_i = 1'b0;
          bus.write_data_i  = {$urandom, $urandom};
          gaps++;
          @(posedge clk); #1;
        end
        bus.write_valid_i = 1'b1;
        bus.write_data_i  = wbeats[k];
        bus.abort_i       = (k == abort_beat);
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        if (k == abort_beat) break;
      end
      bus.write_valid_i = 1'b0;
      if (abort_beat >= 0) begin @(negedge clk); abort_busy = bus.busy_o; end
    end
    t = 0;
    while (t < 60) begin
      @(negedge clk);
      if (!bus.busy_o) break;
      t++;
    end
    if (t >= 60) to_flag = 1;
    bus.write_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_i = 0; bus.write_i = 0; bus.addr_i = 0; bus.size_i = 0;
    bus.write_valid_i = 0; bus.write_data_i = 0; bus.abort_i = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.grant_o !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b expected 0", bus.grant_o); end
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", bus.read_valid_o); end
    checks++; if (bus.read_data_o !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.read_data_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", bus.error_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < MW / 8; i++) begin
      for (int k = 0; k < 4; k++) wbeats[k] = {$urandom, $urandom};
      txn(1, 32'(32 * i), 4'd9, -1, 0);
      model_write(32'(32 * i), 4);
      checks++; if (g_cnt - sg !== 1 || to_flag) begin errors++; $display("FAIL fill_grant[%0d]: got %0d grants (timeout %0d) expected 1", i, g_cnt - sg, to_flag); end
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 4; k++) wbeats[k] = 64'h1111_0000_1111_0001 + 64'(k);
    txn(1, 32'h20, 4'd9, -1, 0);
    model_write(32'h20, 4);
    checks++; if (g_cnt - sg !== 1) begin errors++; $display("FAIL wr_grant: got %0d expected 1", g_cnt - sg); end
    checks++; if (b_cnt - sb !== 5) begin errors++; $display("FAIL wr_busy: got %0d expected 5", b_cnt - sb); end
    checks++; if (e_cnt - se !== 0) begin errors++; $display("FAIL wr_error: got %0d expected 0", e_cnt - se); end
    txn(0, 32'h20, 4'd9, -1, 0);
    checks++; if (rq.size() - sq !== 4) begin errors++; $display("FAIL rd_count: got %0d expected 4", rq.size() - sq); end
    if (rq.size() - sq == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (rq[sq + k] !== 64'h1111_0000_1111_0001 + 64'(k)) begin errors++; $display("FAIL rd_data[%0d]: got %h expected %h", k, rq[sq + k], 64'h1111_0000_1111_0001 + 64'(k)); end
      end
      checks++; if (rc[sq] - g_cyc !== RDL) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", rc[sq] - g_cyc, RDL); end
      for (int k = 1; k < 4; k++) begin
        checks++; if (rc[sq + k] - rc[sq + k - 1] !== 1 + STALL) begin errors++; $display("FAIL rd_spacing[%0d]: got %0d expected %0d", k, rc[sq + k] - rc[sq + k - 1], 1 + STALL); end
      end
    end
    checks++; if (b_cnt - sb !== RDL + (STALL ? 7 : 4)) begin errors++; $display("FAIL rd_busy: got %0d expected %0d", b_cnt - sb, RDL + (STALL ? 7 : 4)); end
  endtask

  task automatic test_read_single();
    wbeats[0] = 64'hDEADBEEF_CAFEF00D;
    txn(1, 32'h0, 4'd3, -1, 0);
    model_write(32'h0, 1);
    txn(0, 32'h0, 4'd3, -1, 0);
    checks++; if (rq.size() - sq !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rq.size() - sq); end
    if (rq.size() - sq == 1) begin
      checks++; if (rq[sq] !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL single_data: got %h expected deadbeefcafef00d", rq[sq]); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [4] = '{32'h40, 32'h4, 32'(4 * MW - 16), 32'h48};
    logic [3:0]  es [4] = '{4'd5, 4'd3, 4'd9, 4'd7};
    bit          ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) wbeats[k] = {$urandom, $urandom};
      txn(ew[i], ea[i], es[i], -1, 0);
      checks++; if (e_cnt - se !== 1) begin errors++; $display("FAIL err_pulse[%0d]: got %0d expected 1", i, e_cnt - se); end
      checks++; if (g_cnt - sg !== 0) begin errors++; $display("FAIL err_grant[%0d]: got %0d expected 0", i, g_cnt - sg); end
      checks++; if (rq.size() - sq !== 0) begin errors++; $display("FAIL err_rvalid[%0d]: got %0d expected 0", i, rq.size() - sq); end
      checks++; if (b_cnt - sb !== 1) begin errors++; $display("FAIL err_busy[%0d]: got %0d expected 1", i, b_cnt - sb); end
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 4; k++) wbeats[k] = {$urandom, $urandom};
    txn(1, 32'h100, 4'd8, -1, 0);
    model_write(32'h100, 3);
    for (int k = 0; k < 4; k++) wbeats[k] = {$urandom, $urandom};
    txn(1, 32'h100, 4'd8, 1, 0);
    model_write(32'h100, 1);
    checks++; if (g_cnt - sg !== 1) begin errors++; $display("FAIL abort_grant: got %0d expected 1", g_cnt - sg); end
    checks++; if (e_cnt - se !== 0) begin errors++; $display("FAIL abort_error: got %0d expected 0", e_cnt - se); end
    checks++; if (abort_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", abort_busy); end
    txn(0, 32'h100, 4'd8, -1, 0);
    checks++; if (rq.size() - sq !== 3) begin errors++; $display("FAIL abort_rd_count: got %0d expected 3", rq.size() - sq); end
    if (rq.size() - sq == 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (rq[sq + k] !== exp_beat(32'h100, k)) begin errors++; $display("FAIL abort_rd_data[%0d]: got %h expected %h", k, rq[sq + k], exp_beat(32'h100, k)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'h20; bus.size_i = 4'd9;
    do begin @(negedge clk); t++; end while (!bus.grant_o && t < 10);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b1 || t >= 10) begin errors++; $display("FAIL mid_pre_rvalid: got %b expected 1", bus.read_valid_o); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus.grant_o, bus.read_valid_o, bus.error_o, bus.busy_o} !== 4'b0) begin errors++; $display("FAIL mid_outputs: got %b expected 0000", {bus.grant_o, bus.read_valid_o, bus.error_o, bus.busy_o}); end
    checks++; if (bus.read_data_o !== 64'd0) begin errors++; $display("FAIL mid_rdata: got %h expected 0", bus.read_data_o); end
    @(negedge clk);
    reset_n = 1'b1;
    txn(0, 32'h20, 4'd9, -1, 0);
    checks++; if (rq.size() - sq !== 4 || to_flag) begin errors++; $display("FAIL mid_rd_count: got %0d expected 4", rq.size() - sq); end
    if (rq.size() - sq == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (rq[sq + k] !== exp_beat(32'h20, k)) begin errors++; $display("FAIL mid_rd_data[%0d]: got %h expected %h", k, rq[sq + k], exp_beat(32'h20, k)); end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] sz [8] = '{4'd3, 4'd8, 4'd9, 4'd3, 4'd8, 4'd9, 4'd5, 4'd0};
    for (int i = 0; i < 40; i++) begin
      bit          wr = 1'($urandom_range(0, 1));
      logic [3:0]  s  = sz[$urandom_range(0, 7)];
      logic [31:0] a;
      int          nb, sel;
      if (s == 4'd0) s = 4'($urandom_range(0, 15));
      nb  = exp_beats(s);
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = 32'(4 * MW - 8 * nb);
      else if (sel == 1) a = 32'(4 * MW - 8 * nb + 8);
      else if (sel == 2) a = 32'($urandom_range(0, 4 * MW - 1)) | 32'h4;
      else               a = 32'($urandom_range(0, 4 * MW - 40)) & ~32'h7;
      for (int k = 0; k < 4; k++) wbeats[k] = {$urandom, $urandom};
      txn(wr, a, s, -1, 1);
      checks++; if (to_flag) begin errors++; $display("FAIL rnd_timeout[%0d]: got 1 expected 0", i); end
      if (exp_err(a, s)) begin
        checks++; if (e_cnt - se !== 1 || g_cnt - sg !== 0 || rq.size() - sq !== 0) begin errors++; $display("FAIL rnd_err[%0d]: got err=%0d grant=%0d beats=%0d expected 1 0 0", i, e_cnt - se, g_cnt - sg, rq.size() - sq); end
      end else begin
        checks++; if (e_cnt - se !== 0 || g_cnt - sg !== 1) begin errors++; $display("FAIL rnd_grant[%0d]: got err=%0d grant=%0d expected 0 1", i, e_cnt - se, g_cnt - sg); end
        if (wr) begin
          model_write(a, nb);
          checks++; if (b_cnt - sb !== 1 + nb + gaps) begin errors++; $display("FAIL rnd_wr_busy[%0d]: got %0d expected %0d", i, b_cnt - sb, 1 + nb + gaps); end
        end else begin
          checks++; if (rq.size() - sq !== nb) begin errors++; $display("FAIL rnd_rd_count[%0d]: got %0d expected %0d", i, rq.size() - sq, nb); end
          checks++; if (b_cnt - sb !== RDL + (STALL ? 2 * nb - 1 : nb)) begin errors++; $display("FAIL rnd_rd_busy[%0d]: got %0d expected %0d", i, b_cnt - sb, RDL + (STALL ? 2 * nb - 1 : nb)); end
          if (rq.size() - sq == nb) begin
            checks++; if (rc[sq] - g_cyc !== RDL) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, rc[sq] - g_cyc, RDL); end
            for (int k = 0; k < nb; k++) begin
              checks++; if (rq[sq + k] !== exp_beat(a, k)) begin errors++; $display("FAIL rnd_rd_data[%0d.%0d]: got %h expected %h", i, k, rq[sq + k], exp_beat(a, k)); end
            end
          end
        end
      end
    end
  endtask

  task automatic test_readback();
    for (int i = 0; i < MW / 8; i++) begin
      txn(0, 32'(32 * i), 4'd9, -1, 0);
      checks++; if (rq.size() - sq !== 4) begin errors++; $display("FAIL rb_count[%0d]: got %0d expected 4", i, rq.size() - sq); end
      if (rq.size() - sq == 4) begin
        for (int k = 0; k < 4; k++) begin
          checks++; if (rq[sq + k] !== exp_beat(32'(32 * i), k)) begin errors++; $display("FAIL rb_data[%0d.%0d]: got %h expected %h", i, k, rq[sq + k], exp_beat(32'(32 * i), k)); end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_read_single();
    test_errors();
    test_abort();
    test_reset_mid();
    test_random();
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_codma_mem_responder.md
Name: ip_codma_mem_responder

Overview:
- Memory-side responder for the codma memory bus: it answers the initiator's read and write requests.
- Arbitrates one request at a time, then issues a one-cycle grant.
- Reads: streams 64-bit beats with read_valid_o. Writes: absorbs 64-bit beats from the initiator.
- Backed by an internal word-addressed RAM. Serves as the bus model in block/system benches and as a scratchpad slave in the design.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the backing RAM; must be a power of 2 and ≥ 8.
- RD_LATENCY, 2, cycles from the grant cycle to the first read beat; range 1..15.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- req_i  in  1  request; held by the initiator until the grant is seen
- write_i  in  1  1 = write request, 0 = read request; sampled with req_i
- addr_i  in  32  byte address; sampled with req_i
- size_i  in  4  transfer size code; sampled with req_i
- write_valid_i  in  1  write beat valid
- write_data_i  in  64  write beat: [31:0] goes to the lower address, [63:32] to the upper
- abort_i  in  1  abandons the current transfer
- grant_o  out  1  one-cycle grant pulse
- read_valid_o  out  1  read beat valid
- read_data_o  out  64  read beat, same word packing as write_data_i
- error_o  out  1  one-cycle error pulse
- busy_o  out  1  high in every state other than RSP_IDLE

Behaviour:
- Reset values: all outputs 0, state RSP_IDLE, internal counters 0. RAM contents are not reset.
- Size codes (beats = 2 words each):
  - 3 → 1 beat (2 words)
  - 8 → 3 beats (6 words)
  - 9 → 4 beats (8 words)
  - any other code is illegal.
- States: RSP_IDLE, RSP_GRANT, RSP_RD_WAIT, RSP_RD_BEAT, RSP_WR_BEAT, RSP_ERROR.
- RSP_IDLE:
  - On req_i, latch addr/size/write.
  - Error check: illegal size, addr[2:0] != 0, or addr + 8*beats > 4*MEM_WORDS → RSP_ERROR.
  - Otherwise → RSP_GRANT.
- RSP_GRANT: grant_o = 1 for exactly this one cycle. Next state is RSP_RD_WAIT for a read, RSP_WR_BEAT for a write.
- RSP_RD_WAIT:
  - Counts RD_LATENCY-1 cycles, issuing RAM reads so data is registered.
  - The first beat appears exactly RD_LATENCY cycles after the grant cycle. With RD_LATENCY=1, read_valid_o is asserted the cycle after grant.
  - Then → RSP_RD_BEAT.
- RSP_RD_BEAT:
  - read_valid_o = 1 per beat.
  - Beat k carries words at addr+8k and addr+8k+4.
  - Beats are back-to-back; the initiator has no backpressure.
  - After the last beat → RSP_IDLE.
- RSP_WR_BEAT:
  - Each cycle with write_valid_i writes both words at the current beat address and increments the beat counter.
  - After the last beat is accepted → RSP_IDLE.
  - write_valid_i outside RSP_WR_BEAT is ignored.
- RSP_ERROR: error_o = 1 for one cycle → RSP_IDLE. No grant is issued and the RAM is not modified.
- abort_i in any non-idle state:
  - Next state is RSP_IDLE; any beat in flight that cycle is dropped.
  - A write beat coincident with abort is not written.
  - No error_o.
- req_i held high in RSP_IDLE after the previous transfer completes is treated as a new request. The initiator must drop req_i upon grant.
- Address arithmetic: word index = addr[31:2] truncated to $clog2(MEM_WORDS) bits. The range check above guarantees no wrap-around inside a transfer.
- Reset mid-transfer: asynchronous return to RSP_IDLE, outputs forced to 0, partially written RAM words kept.

Optional Feature:
- Macro: CODMA_RSP_STALL_EN.
- Defined: in RSP_RD_BEAT, read_valid_o is deasserted for one idle cycle between consecutive beats, so a 4-beat read spans 7 cycles. Write behaviour is unchanged.
- Undefined: read beats are strictly back-to-back.

Decomposition:
- ip_codma_pkg gains:
  - rsp_state_t
  - size code constants CODMA_SIZE_2W=3, CODMA_SIZE_6W=8, CODMA_SIZE_8W=9
  - function codma_size_to_beats(size) returning 0 for illegal codes.
- Sub-module ip_codma_rsp_ram: MEM_WORDS x 32 dual-word RAM with one 64-bit synchronous read port and one 64-bit write port with write enable. The FSM lives in the top module.

Test Plan:
- Reset, then write size=9 at addr 0x20 with beats {0x1111_0000_1111_0001 .. 4 beats} → one grant pulse, busy_o=1 until the 4th beat, then idle. A subsequent read size=9 at 0x20 returns the same 4 beats, the first read_valid exactly RD_LATENCY=2 cycles after grant, with no gaps.
- Read size=3 at 0x0 after writing 0xDEADBEEF_CAFEF00D → exactly one read_valid_o beat carrying 0xDEADBEEF_CAFEF00D.
- Read size=5, read at addr 0x4, and read size=9 at addr 4*MEM_WORDS-16 → each gives error_o for one cycle, no grant_o, no read_valid_o, and the RAM is unchanged.
- abort_i asserted during the 2nd beat of a size=8 write → busy_o drops the next cycle, beats 2 and 3 are not written (read back shows old data), and error_o stays 0.
- reset_n_i pulsed low mid-read → all outputs 0 asynchronously, and a new read after reset completes normally.
- With CODMA_RSP_STALL_EN defined, read size=9 → read_valid_o pattern 1010101, 4 beats in 7 cycles.
